// File: rtl/data_mem_responder.sv
// Responder end of the Core data-memory interface: serialises one request at a time,
// inserts WAIT_CYCLES wait states, then completes against an internal word array.
// Optional macro MEM_STAT_EN adds stall-cycle and access-count statistics outputs.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Mem_ready,
    output logic        Mem_stall,
    output logic        Addr_error
`ifdef MEM_STAT_EN
    ,
    output logic [31:0] prob_stall_cycles,
    output logic [31:0] prob_access_count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [3:0]              counter_reg;
    logic [ADDR_WIDTH-1:0]   addr_idx_reg;
    logic [31:0]             wdata_reg;
    logic                    is_write_reg;
    logic                    err_reg;
    logic [31:0]             mem_array [DEPTH];

    logic request;
    logic req_err;

    assign request = MemRead | MemWrite;

    // Misaligned, beyond the array, or an ambiguous read+write request.
    assign req_err = (Address[1:0] != 2'b00)
                   || ((Address >> (ADDR_WIDTH + 2)) != 32'd0)
                   || (MemRead && MemWrite);

    assign Mem_stall = ((state_reg == ST_IDLE) && request) || (state_reg == ST_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            counter_reg  <= 4'd0;
            addr_idx_reg <= '0;
            wdata_reg    <= 32'd0;
            is_write_reg <= 1'b0;
            err_reg      <= 1'b0;
            Read_data    <= 32'd0;
            Mem_ready    <= 1'b0;
            Addr_error   <= 1'b0;
        end else begin
            Mem_ready  <= 1'b0;
            Addr_error <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (request) begin
                        addr_idx_reg <= Address[ADDR_WIDTH+1:2];
                        wdata_reg    <= Write_data;
                        is_write_reg <= MemWrite;
                        err_reg      <= req_err;
                        if (WAIT_CYCLES > 0) begin
                            state_reg   <= ST_WAIT;
                            counter_reg <= WAIT_INIT;
                        end else begin
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (counter_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        counter_reg <= counter_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    Mem_ready  <= 1'b1;
                    Addr_error <= err_reg;
                    if (err_reg) begin
                        Read_data <= 32'd0;
                    end else if (!is_write_reg) begin
                        Read_data <= mem_array[addr_idx_reg];
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Array is never cleared; a reset landing on the completion edge cancels the store.
    always_ff @(posedge clk) begin
        if ((state_reg == ST_RESP) && is_write_reg && !err_reg && !reset) begin
            mem_array[addr_idx_reg] <= wdata_reg;
        end
    end

`ifdef MEM_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prob_stall_cycles <= 32'd0;
            prob_access_count <= 32'd0;
        end else begin
            if (Mem_stall) begin
                prob_stall_cycles <= prob_stall_cycles + 32'd1;
            end
            if (Mem_ready) begin
                prob_access_count <= prob_access_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) driven by directed
// and random transactions, checked against a word-array reference model.
module tb_data_mem_responder;

    logic              clk;
    logic [1:0]        rst;
    logic [1:0]        mrd;
    logic [1:0]        mwr;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdat;
    logic [1:0][31:0]  rdat;
    logic [1:0]        rdy;
    logic [1:0]        stall;
    logic [1:0]        aerr;
`ifdef MEM_STAT_EN
    logic [1:0][31:0]  st_cyc;
    logic [1:0][31:0]  st_acc;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] ref_mem [2][256];
    bit          known   [2][256];
    logic [31:0] exp_rd  [2];
    bit          exp_rd_known [2];
    int          exp_acc [2];
    int          exp_stall [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            data_mem_responder #(
                .ADDR_WIDTH (8),
                .WAIT_CYCLES((gi == 0) ? 2 : 0)
            ) u_dut (
                .clk       (clk),
                .reset     (rst[gi]),
                .MemRead   (mrd[gi]),
                .MemWrite  (mwr[gi]),
                .Address   (addr[gi]),
                .Write_data(wdat[gi]),
                .Read_data (rdat[gi]),
                .Mem_ready (rdy[gi]),
                .Mem_stall (stall[gi]),
                .Addr_error(aerr[gi])
`ifdef MEM_STAT_EN
                ,
                .prob_stall_cycles(st_cyc[gi]),
                .prob_access_count(st_acc[gi])
`endif
            );
        end
    endgenerate

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int d);
        exp_rd[d]       = 32'd0;
        exp_rd_known[d] = 1'b1;
        exp_acc[d]      = 0;
        exp_stall[d]    = 0;
    endtask

    task automatic check_stats(input int d);
`ifdef MEM_STAT_EN
        check_val($sformatf("dut%0d stat_access", d), st_acc[d], 32'(exp_acc[d]));
        check_val($sformatf("dut%0d stat_stall", d), st_cyc[d], 32'(exp_stall[d]));
`else
        check_val($sformatf("dut%0d idle_ready", d), {31'd0, rdy[d]}, 32'd0);
`endif
    endtask

    // Reset the instance, then idle five cycles checking the quiescent outputs.
    task automatic do_reset(input int d);
        mrd[d] = 1'b0;
        mwr[d] = 1'b0;
        rst[d] = 1'b1;
        repeat (2) @(negedge clk);
        rst[d] = 1'b0;
        model_reset(d);
        repeat (5) @(negedge clk);
        check_val($sformatf("dut%0d rst_rdata", d), rdat[d], 32'd0);
        check_val($sformatf("dut%0d rst_ready", d), {31'd0, rdy[d]}, 32'd0);
        check_val($sformatf("dut%0d rst_stall", d), {31'd0, stall[d]}, 32'd0);
        check_val($sformatf("dut%0d rst_aerr", d), {31'd0, aerr[d]}, 32'd0);
        check_stats(d);
    endtask

    // Presents one request at the current negedge and follows it to Mem_ready.
    // Returns at the negedge inside the Mem_ready cycle with the request dropped.
    task automatic do_txn(input int d, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd);
        int  stall_cnt;
        int  lat;
        bit  got;
        bit  err;
        int  w;
        mrd[d]  = rd;
        mwr[d]  = wr;
        addr[d] = a;
        wdat[d] = wd;
        #1;
        stall_cnt = stall[d] ? 1 : 0;
        lat = 0;
        got = 1'b0;
        for (int j = 1; j <= 40 && !got; j++) begin
            @(negedge clk);
            if (rdy[d]) begin
                got = 1'b1;
                lat = j;
            end else if (stall[d]) begin
                stall_cnt++;
            end
        end
        if (!got) begin
            check_val($sformatf("dut%0d ready_timeout", d), 32'd0, 32'd1);
        end else begin
            check_val($sformatf("dut%0d latency", d), 32'(lat), 32'(wc(d) + 2));
            check_val($sformatf("dut%0d stall_cycles", d), 32'(stall_cnt), 32'(wc(d) + 1));
            err = (a % 4 != 0) || (a >= 32'd1024) || (rd && wr);
            w   = int'(a / 4);
            check_val($sformatf("dut%0d addr_error", d), {31'd0, aerr[d]}, {31'd0, err});
            if (err) begin
                exp_rd[d]       = 32'd0;
                exp_rd_known[d] = 1'b1;
            end else if (wr) begin
                ref_mem[d][w] = wd;
                known[d][w]   = 1'b1;
            end else begin
                exp_rd[d]       = ref_mem[d][w];
                exp_rd_known[d] = known[d][w];
            end
            if (exp_rd_known[d]) begin
                check_val($sformatf("dut%0d read_data", d), rdat[d], exp_rd[d]);
            end
            exp_acc[d]   = exp_acc[d] + 1;
            exp_stall[d] = exp_stall[d] + wc(d) + 1;
        end
        $display("dut%0d %s addr=%h wdata=%h rdata=%h aerr=%0d lat=%0d",
                 d, (rd && wr) ? "RW" : (wr ? "WR" : "RD"), a, wd, rdat[d], aerr[d], lat);
        mrd[d] = 1'b0;
        mwr[d] = 1'b0;
    endtask

    // Reset one cycle after acceptance must cancel the pending write.
    task automatic do_abort(input int d);
        mrd[d]  = 1'b0;
        mwr[d]  = 1'b1;
        addr[d] = 32'h8;
        wdat[d] = 32'h0000CAFE;
        @(negedge clk);
        mwr[d] = 1'b0;
        rst[d] = 1'b1;
        @(negedge clk);
        rst[d] = 1'b0;
        model_reset(d);
        $display("dut%0d WR addr=%h wdata=%h aborted by reset", d, 32'h8, 32'h0000CAFE);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_val($sformatf("dut%0d abort_ready", d), {31'd0, rdy[d]}, 32'd0);
            check_val($sformatf("dut%0d abort_stall", d), {31'd0, stall[d]}, 32'd0);
        end
    endtask

    task automatic run_dut(input int d);
        int          mode;
        logic [31:0] a;
        bit          rd;
        bit          wr;
        do_reset(d);
        do_txn(d, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_txn(d, 1'b1, 1'b0, 32'h10, 32'h0);
        do_txn(d, 1'b0, 1'b1, 32'h0, 32'h00001111);
        do_txn(d, 1'b0, 1'b1, 32'h4, 32'h00002222);
        do_txn(d, 1'b1, 1'b0, 32'h4, 32'h0);
        do_txn(d, 1'b1, 1'b0, 32'h0, 32'h0);
        do_txn(d, 1'b0, 1'b1, 32'h6, 32'h00005A5A);
        do_txn(d, 1'b1, 1'b0, 32'h4, 32'h0);
        do_txn(d, 1'b1, 1'b0, 32'h400, 32'h0);
        do_txn(d, 1'b1, 1'b1, 32'h0, 32'h00009999);
        do_txn(d, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_stats(d);
        do_txn(d, 1'b0, 1'b1, 32'h8, 32'h12345678);
        @(negedge clk);
        do_abort(d);
        do_txn(d, 1'b1, 1'b0, 32'h8, 32'h0);
        do_txn(d, 1'b0, 1'b1, 32'hC, 32'hA5A5A5A5);
        do_txn(d, 1'b1, 1'b0, 32'hC, 32'h0);
        do_txn(d, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check_stats(d);
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 9));
            rd   = $urandom_range(0, 1) == 1;
            wr   = !rd;
            a    = $urandom_range(0, 15) * 4;
            if (mode == 7) a = a | 32'($urandom_range(1, 3));
            if (mode == 8) a = 32'($urandom_range(256, 4095)) << 2;
            if (mode == 9) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            do_txn(d, rd, wr, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        check_stats(d);
    endtask

    initial begin
        rst  = 2'b11;
        mrd  = '0;
        mwr  = '0;
        addr = '0;
        wdat = '0;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 256; w++) begin
                known[d][w]   = 1'b0;
                ref_mem[d][w] = 32'd0;
            end
            model_reset(d);
        end
        @(negedge clk);
        run_dut(0);
        run_dut(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
